// File: rtl/cpu_reset_ctrl.sv
// Reset sequencer and run/halt/single-step controller for the mips core.
// Optional free-running enabled-cycle counter: define CPU_RESET_CTRL_CYCLE_CNT_EN.
`timescale 1ns/1ps
module cpu_reset_ctrl #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter bit          AUTO_RUN    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       soft_reset,
  input  logic       run_req,
  input  logic       halt_req,
  input  logic       step_req,
  input  logic [7:0] step_count,
  output logic       core_reset,
  output logic       core_en,
  output logic [1:0] state,
  output logic       step_done
`ifdef CPU_RESET_CTRL_CYCLE_CNT_EN
  ,
  output logic [31:0] cycle_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_HALT = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  logic       sync1_r;
  logic       sync2_r;
  state_t     state_r;
  logic [7:0] hold_cnt_r;
  logic [7:0] remaining_r;
  logic       core_reset_r;
  logic       core_en_r;
  logic       step_done_r;

  // Two-flop release synchroniser for the external reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= 1'b1;
      sync2_r <= sync1_r;
    end
  end

  // Sequencing FSM with registered core controls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_HOLD;
      hold_cnt_r   <= 8'd0;
      remaining_r  <= 8'd0;
      core_reset_r <= 1'b1;
      core_en_r    <= 1'b0;
      step_done_r  <= 1'b0;
    end else if (soft_reset) begin
      state_r      <= ST_HOLD;
      hold_cnt_r   <= 8'd0;
      remaining_r  <= 8'd0;
      core_reset_r <= 1'b1;
      core_en_r    <= 1'b1;
      step_done_r  <= 1'b0;
    end else begin
      step_done_r <= 1'b0;
      case (state_r)
        ST_HOLD: begin
          // core_en follows the value rst_sync is about to take, so both rise together.
          if (!sync2_r) begin
            core_reset_r <= 1'b1;
            core_en_r    <= sync1_r;
          end else if (hold_cnt_r == HOLD_LAST) begin
            core_reset_r <= 1'b0;
            hold_cnt_r   <= 8'd0;
            if (AUTO_RUN) begin
              state_r   <= ST_RUN;
              core_en_r <= 1'b1;
            end else begin
              state_r   <= ST_HALT;
              core_en_r <= 1'b0;
            end
          end else begin
            core_reset_r <= 1'b1;
            core_en_r    <= 1'b1;
            hold_cnt_r   <= hold_cnt_r + 8'd1;
          end
        end
        ST_HALT: begin
          if (halt_req) begin
            core_en_r <= 1'b0;
          end else if (step_req && (step_count != 8'd0)) begin
            state_r     <= ST_STEP;
            remaining_r <= step_count;
            core_en_r   <= 1'b1;
          end else if (run_req) begin
            state_r   <= ST_RUN;
            core_en_r <= 1'b1;
          end else begin
            core_en_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (halt_req) begin
            state_r   <= ST_HALT;
            core_en_r <= 1'b0;
          end else begin
            core_en_r <= 1'b1;
          end
        end
        ST_STEP: begin
          if (halt_req) begin
            state_r     <= ST_HALT;
            remaining_r <= 8'd0;
            core_en_r   <= 1'b0;
          end else if (remaining_r == 8'd1) begin
            state_r     <= ST_HALT;
            remaining_r <= 8'd0;
            core_en_r   <= 1'b0;
            step_done_r <= 1'b1;
          end else begin
            remaining_r <= remaining_r - 8'd1;
            core_en_r   <= 1'b1;
          end
        end
        default: begin
          state_r      <= ST_HOLD;
          hold_cnt_r   <= 8'd0;
          remaining_r  <= 8'd0;
          core_reset_r <= 1'b1;
          core_en_r    <= 1'b0;
        end
      endcase
    end
  end

`ifdef CPU_RESET_CTRL_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_r;

  // Counts edges on which the core is enabled and out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_r <= 32'd0;
    end else if (soft_reset) begin
      cycle_cnt_r <= 32'd0;
    end else if (core_en_r && !core_reset_r) begin
      cycle_cnt_r <= cycle_cnt_r + 32'd1;
    end else begin
      cycle_cnt_r <= cycle_cnt_r;
    end
  end

  assign cycle_cnt = cycle_cnt_r;
`endif

  assign core_reset = core_reset_r;
  assign core_en    = core_en_r;
  assign state      = state_r;
  assign step_done  = step_done_r;

endmodule
